sq_register_param: RTL and testbench

- Parametrised successor of the instruction sequence (SQ) register, built as a behavioural, clocked block.
- Holds the opcode field, quarter-code and SQR10 bit of the current instruction, and decodes them one-hot.
- Tracks pending EXTEND prefixes as a multi-level extension count, plus the INHINT and interrupt-in-progress (IIP) flags.
- Forces the interrupt (RUPT) code into SQ at instruction load when an interrupt is allowed.
- Sits between the write bus (WL) and the control-pulse generator.

---
 rtl/sq_register_param_if.sv | 42 ++++
 rtl/sq_register_param.sv | 109 ++++++++++
 tb/tb_sq_register_param.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/sq_register_param_if.sv
// Bus bundle between the write bus / control-pulse sources and the SQ register.
// master drives the instruction word and control pulses, slave is the SQ register.
interface sq_register_param_if #(
    parameter int OP_W       = 3,
    parameter int QC_W       = 2,
    parameter int EXT_LEVELS = 1
);
    localparam int W  = OP_W + QC_W + 1;
    localparam int EW = $clog2(EXT_LEVELS + 1);

    logic                 T12;
    logic                 NISQ;
    logic [W-1:0]         WL;
    logic                 EXTPLS;
    logic                 INHPLS;
    logic                 RELPLS;
    logic                 KRPT;
    logic                 RUPT_REQ;
    logic                 OVNHRP;
    logic                 MNHRPT;

    logic [2**OP_W-1:0]   SQ_OH;
    logic [2**QC_W-1:0]   QC_OH;
    logic                 SQR10;
    logic [EW-1:0]        SQEXT;
    logic                 EXST0;
    logic [EW-1:0]        FUTEXT;
    logic                 INHINT;
    logic                 IIP;
    logic                 STRTFC;
    logic                 RPTFRC;

    modport master (
        output T12, NISQ, WL, EXTPLS, INHPLS, RELPLS, KRPT, RUPT_REQ, OVNHRP, MNHRPT,
        input  SQ_OH, QC_OH, SQR10, SQEXT, EXST0, FUTEXT, INHINT, IIP, STRTFC, RPTFRC
    );

    modport slave (
        input  T12, NISQ, WL, EXTPLS, INHPLS, RELPLS, KRPT, RUPT_REQ, OVNHRP, MNHRPT,
        output SQ_OH, QC_OH, SQR10, SQEXT, EXST0, FUTEXT, INHINT, IIP, STRTFC, RPTFRC
    );
endinterface

// File: rtl/sq_register_param.sv
// Instruction sequence (SQ) register: latches opcode / quarter-code / SQR10
// at T12 of a next-instruction cycle, tracks chained EXTEND prefixes, the
// INHINT and interrupt-in-progress flags, and substitutes the RUPT code when
// an interrupt is allowed at load time.
module sq_register_param #(
    parameter int OP_W       = 3,
    parameter int QC_W       = 2,
    parameter int EXT_LEVELS = 1,
    parameter logic [OP_W+QC_W:0] RUPT_CODE = '1
) (
    input  logic CLOCK,
    input  logic SIM_RST,
    input  logic GOJAM,
    sq_register_param_if.slave bus
);
    localparam int W  = OP_W + QC_W + 1;
    localparam int EW = $clog2(EXT_LEVELS + 1);
    localparam logic [EW-1:0] EXT_MAX = EW'(EXT_LEVELS);

    logic [W-1:0]       sq_q;
    logic [EW-1:0]      sqext_q;
    logic [EW-1:0]      futext_q;
    logic               nisql_q;
    logic               inhint_q;
    logic               iip_q;
    logic               strtfc_q;
    logic               rptfrc_q;

    logic               clr;
    logic               load;
    logic               rupt_ok;
    logic [2**OP_W-1:0] sq_oh;
    logic [2**QC_W-1:0] qc_oh;

    assign clr     = SIM_RST | GOJAM;
    // A NISQ arriving in the T12 cycle itself still loads, so it bypasses the latch.
    assign load    = bus.T12 & (nisql_q | bus.NISQ);
    assign rupt_ok = bus.RUPT_REQ & ~inhint_q & ~iip_q & ~bus.OVNHRP & ~bus.MNHRPT
                     & (futext_q == '0);

    // Instruction word, extension level and load strobes.
    always_ff @(posedge CLOCK) begin
        if (clr) begin
            sq_q     <= '0;
            sqext_q  <= '0;
            futext_q <= '0;
            strtfc_q <= 1'b0;
            rptfrc_q <= 1'b0;
        end else begin
            strtfc_q <= load;
            rptfrc_q <= load & rupt_ok;
            if (load && rupt_ok) begin
                // futext_q is necessarily zero here, so it is left alone.
                sq_q    <= RUPT_CODE;
                sqext_q <= '0;
            end else if (load) begin
                sq_q     <= bus.WL;
                sqext_q  <= futext_q;
                futext_q <= bus.EXTPLS ? EW'(1) : '0;
            end else if (bus.EXTPLS && futext_q != EXT_MAX) begin
                futext_q <= futext_q + EW'(1);
            end
        end
    end

    // Pending-instruction latch and interrupt flags.
    always_ff @(posedge CLOCK) begin
        if (clr) begin
            nisql_q  <= 1'b0;
            inhint_q <= 1'b0;
            iip_q    <= 1'b0;
        end else begin
            if (load)
                nisql_q <= 1'b0;
            else if (bus.NISQ)
                nisql_q <= 1'b1;

            if (bus.INHPLS)
                inhint_q <= 1'b1;
            else if (bus.RELPLS)
                inhint_q <= 1'b0;

            // Entering an interrupt outranks a coincident resume.
            if (load && rupt_ok)
                iip_q <= 1'b1;
            else if (bus.KRPT)
                iip_q <= 1'b0;
        end
    end

    // One-hot decode of the opcode and quarter-code fields.
    always_comb begin
        sq_oh = '0;
        qc_oh = '0;
        sq_oh[sq_q[W-1 -: OP_W]] = 1'b1;
        qc_oh[sq_q[QC_W:1]]      = 1'b1;
    end

    assign bus.SQ_OH  = sq_oh;
    assign bus.QC_OH  = qc_oh;
    assign bus.SQR10  = sq_q[0];
    assign bus.SQEXT  = sqext_q;
    assign bus.EXST0  = (sqext_q == '0);
    assign bus.FUTEXT = futext_q;
    assign bus.INHINT = inhint_q;
    assign bus.IIP    = iip_q;
    assign bus.STRTFC = strtfc_q;
    assign bus.RPTFRC = rptfrc_q;
endmodule

// File: tb/tb_sq_register_param.sv
// Directed bench for sq_register_param: default instance plus an EXT_LEVELS=3
// instance for extension saturation. Load expectations go through a queue.
module tb_sq_register_param;
    logic clk = 1'b0;
    logic sim_rst = 1'b1;
    logic gojam = 1'b0;
    int   total = 0;
    int   bad = 0;

    typedef struct {
        logic [7:0] sq_oh;
        logic [3:0] qc_oh;
        logic       sqr10;
        logic       sqext;
        logic       rpt;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    sq_register_param_if u_if ();
    sq_register_param_if #(.EXT_LEVELS(3)) u_if3 ();

    sq_register_param u_dut (
        .CLOCK(clk), .SIM_RST(sim_rst), .GOJAM(gojam), .bus(u_if.slave)
    );
    sq_register_param #(.EXT_LEVELS(3)) u_dut3 (
        .CLOCK(clk), .SIM_RST(sim_rst), .GOJAM(gojam), .bus(u_if3.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Issue NISQ, then T12 'gap' cycles later (gap=0: coincident), and score the result.
    task automatic load_instr(input string tag, input logic [5:0] wl, input bit rupt,
                              input logic ext, input int gap);
        exp_t e;
        logic [5:0] s;
        s       = rupt ? 6'h3F : wl;
        e.sq_oh = 8'h01 << s[5:3];
        e.qc_oh = 4'h1 << s[2:1];
        e.sqr10 = s[0];
        e.sqext = ext;
        e.rpt   = rupt;
        sb.push_back(e);
        u_if.WL = wl;
        if (gap == 0) begin
            u_if.NISQ = 1'b1;
            u_if.T12  = 1'b1;
            tick();
            u_if.NISQ = 1'b0;
            u_if.T12  = 1'b0;
        end else begin
            u_if.NISQ = 1'b1;
            tick();
            u_if.NISQ = 1'b0;
            repeat (gap - 1) tick();
            check({tag, "_noload_wo_t12"}, u_if.STRTFC, 0);
            u_if.T12 = 1'b1;
            tick();
            u_if.T12 = 1'b0;
        end
        for (int i = 0; i < 4 && u_if.STRTFC !== 1'b1; i++) tick();
        check({tag, "_strtfc"}, u_if.STRTFC, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_sq_oh"},  u_if.SQ_OH,  e.sq_oh);
            check({tag, "_qc_oh"},  u_if.QC_OH,  e.qc_oh);
            check({tag, "_sqr10"},  u_if.SQR10,  e.sqr10);
            check({tag, "_sqext"},  u_if.SQEXT,  e.sqext);
            check({tag, "_exst0"},  u_if.EXST0,  !e.sqext);
            check({tag, "_rptfrc"}, u_if.RPTFRC, e.rpt);
        end
        tick();
        check({tag, "_strtfc_off"}, u_if.STRTFC, 0);
        check({tag, "_rptfrc_off"}, u_if.RPTFRC, 0);
    endtask

    task automatic pulse(input int which);
        case (which)
            0: u_if.EXTPLS = 1'b1;
            1: u_if.INHPLS = 1'b1;
            2: u_if.RELPLS = 1'b1;
            3: u_if.KRPT   = 1'b1;
            default: u_if3.EXTPLS = 1'b1;
        endcase
        tick();
        u_if.EXTPLS = 1'b0; u_if.INHPLS = 1'b0; u_if.RELPLS = 1'b0;
        u_if.KRPT = 1'b0; u_if3.EXTPLS = 1'b0;
    endtask

    initial begin
        {u_if.T12, u_if.NISQ, u_if.EXTPLS, u_if.INHPLS, u_if.RELPLS} = '0;
        {u_if.KRPT, u_if.RUPT_REQ, u_if.OVNHRP, u_if.MNHRPT} = '0;
        u_if.WL = '0;
        {u_if3.T12, u_if3.NISQ, u_if3.EXTPLS, u_if3.INHPLS, u_if3.RELPLS} = '0;
        {u_if3.KRPT, u_if3.RUPT_REQ, u_if3.OVNHRP, u_if3.MNHRPT} = '0;
        u_if3.WL = '0;

        // Reset
        tick(); tick();
        sim_rst = 1'b0;
        tick();
        check("rst_sq_oh",  u_if.SQ_OH,  8'h01);
        check("rst_qc_oh",  u_if.QC_OH,  4'h1);
        check("rst_sqr10",  u_if.SQR10,  0);
        check("rst_exst0",  u_if.EXST0,  1);
        check("rst_inhint", u_if.INHINT, 0);
        check("rst_iip",    u_if.IIP,    0);
        check("rst_futext", u_if.FUTEXT, 0);
        check("rst_strtfc", u_if.STRTFC, 0);

        // Plain load, T12 three cycles after NISQ
        load_instr("plain", 6'b101_10_1, 0, 0, 3);
        load_instr("coinc", 6'b010_01_0, 0, 0, 0);

        // Extend, saturating at 1 on the default instance
        pulse(0);
        check("ext_futext1", u_if.FUTEXT, 1);
        pulse(0);
        check("ext_futext_sat", u_if.FUTEXT, 1);
        load_instr("ext_load", 6'b011_00_0, 0, 1, 3);
        check("ext_futext_clr", u_if.FUTEXT, 0);
        load_instr("ext_next", 6'b100_11_1, 0, 0, 2);

        // EXT_LEVELS=3 saturation
        for (int i = 1; i <= 4; i++) begin
            pulse(4);
            check($sformatf("ext3_futext_%0d", i), u_if3.FUTEXT, (i > 3) ? 3 : i);
        end

        // Interrupt
        u_if.RUPT_REQ = 1'b1;
        load_instr("rupt", 6'b001_01_0, 1, 0, 3);
        check("rupt_iip", u_if.IIP, 1);
        load_instr("rupt_iip_blk", 6'b010_01_0, 0, 0, 3);
        pulse(3);
        check("krpt_iip", u_if.IIP, 0);

        // Inhibits
        pulse(1);
        check("inh_set", u_if.INHINT, 1);
        load_instr("inh_blk", 6'b110_00_1, 0, 0, 3);
        pulse(2);
        check("inh_rel", u_if.INHINT, 0);
        u_if.OVNHRP = 1'b1;
        load_instr("ovn_blk", 6'b001_10_1, 0, 0, 3);
        u_if.OVNHRP = 1'b0;
        u_if.MNHRPT = 1'b1;
        load_instr("mnh_blk", 6'b011_11_0, 0, 0, 3);
        u_if.MNHRPT = 1'b0;
        pulse(0);
        load_instr("fut_blk", 6'b000_01_1, 0, 1, 3);
        u_if.INHPLS = 1'b1;
        u_if.RELPLS = 1'b1;
        tick();
        u_if.INHPLS = 1'b0;
        u_if.RELPLS = 1'b0;
        check("inh_both", u_if.INHINT, 1);
        pulse(2);

        // Mid-operation GOJAM
        load_instr("gj_rupt", 6'b000_00_0, 1, 0, 3);
        u_if.RUPT_REQ = 1'b0;
        load_instr("gj_setup", 6'b110_11_0, 0, 0, 3);
        pulse(0);
        pulse(1);
        check("gj_pre_futext", u_if.FUTEXT, 1);
        check("gj_pre_inhint", u_if.INHINT, 1);
        check("gj_pre_iip",    u_if.IIP,    1);
        check("gj_pre_sq_oh",  u_if.SQ_OH,  8'h40);
        u_if.WL = 6'b111_01_1;
        u_if.NISQ = 1'b1;
        u_if.T12 = 1'b1;
        gojam = 1'b1;
        tick();
        u_if.NISQ = 1'b0;
        u_if.T12 = 1'b0;
        gojam = 1'b0;
        check("gj_sq_oh",  u_if.SQ_OH,  8'h01);
        check("gj_qc_oh",  u_if.QC_OH,  4'h1);
        check("gj_sqr10",  u_if.SQR10,  0);
        check("gj_exst0",  u_if.EXST0,  1);
        check("gj_futext", u_if.FUTEXT, 0);
        check("gj_inhint", u_if.INHINT, 0);
        check("gj_iip",    u_if.IIP,    0);
        check("gj_strtfc", u_if.STRTFC, 0);
        check("gj_rptfrc", u_if.RPTFRC, 0);
        u_if.T12 = 1'b1;
        tick();
        u_if.T12 = 1'b0;
        tick();
        check("gj_nisql_clr", u_if.STRTFC, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
